simple_io_unit: RTL and testbench

- I/O endpoint for the 16-bit core's IN/OUT instructions: decodes instr[15:14]=2'b11 with op3=instr[7:4] = 4'b1100 (IN) or 4'b1101 (OUT).
- IN: supplies the ALU's iData from a one-entry input holding register filled by an external valid/ready producer.
- OUT: buffers the ALU's pass-through rs value in a small FIFO drained by an external valid/ready consumer.
- Stalls the core while the required data or space is not available.

---
 rtl/simple_io_unit.sv | 149 ++++++++++++++
 tb/tb_simple_io_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_io_unit.sv
// I/O endpoint for the core's IN/OUT instructions: a one-entry input holding register
// and an output FIFO, each behind a valid/ready handshake, with core stall generation.
module simple_io_unit #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              exec,
    input  logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] i_data,
    output logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PtrW = $clog2(OUT_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StInWait, StOutWait} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] in_buf_q, in_buf_d;
    logic              in_buf_valid_q, in_buf_valid_d;
    logic [DATA_W-1:0] mem_q [OUT_DEPTH];
    logic [DATA_W-1:0] mem_d [OUT_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic is_in, is_out, full, stall_raw;
    logic push, pop, consume, capture;

    always_comb begin
        is_in     = exec && (instr[15:14] == 2'b11) && (instr[7:4] == 4'b1100);
        is_out    = exec && (instr[15:14] == 2'b11) && (instr[7:4] == 4'b1101);
        full      = (count_q == CntW'(OUT_DEPTH));
        stall_raw = (is_in && !in_buf_valid_q) || (is_out && full);
        // Fullness comes from the registered count, so a same-cycle pop cannot unblock a push.
        push      = is_out && !full;
        pop       = (count_q != '0) && out_ready;
        consume   = is_in && in_buf_valid_q;
        capture   = in_valid && !in_buf_valid_q;
    end

    always_comb begin
        in_buf_d       = in_buf_q;
        in_buf_valid_d = in_buf_valid_q;
        if (consume) begin
            in_buf_valid_d = 1'b0;
        end else if (capture) begin
            in_buf_d       = in_data;
            in_buf_valid_d = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rs_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_raw && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (is_in && !in_buf_valid_q) begin
                    state_d = StInWait;
                end else if (is_out && full) begin
                    state_d = StOutWait;
                end
            end
            // Losing the instruction (exec drop) abandons the wait without side effects.
            StInWait: begin
                if (!is_in || in_buf_valid_q) begin
                    state_d = StIdle;
                end
            end
            StOutWait: begin
                if (!is_out || push) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            in_buf_q       <= '0;
            in_buf_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            in_buf_q       <= in_buf_d;
            in_buf_valid_q <= in_buf_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    assign i_data    = in_buf_q;
    assign in_ready  = !in_buf_valid_q;
    assign stall     = !rst && stall_raw;
    assign out_valid = (count_q != '0);
    assign out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_simple_io_unit.sv
// Scoreboarded bench for simple_io_unit: directed scenarios followed by random traffic,
// checked against a queue-based model of the input register and output FIFO.
module tb_simple_io_unit;

    localparam int unsigned DataW = 16;
    localparam int unsigned Depth = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      instr;
    logic             exec;
    logic [DataW-1:0] rs_data;
    logic [DataW-1:0] i_data;
    logic             stall;
    logic             in_valid;
    logic [DataW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DataW-1:0] out_data;
    logic             out_ready;
    logic [15:0]      stall_cnt;

    simple_io_unit #(.DATA_W(DataW), .OUT_DEPTH(Depth)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .exec      (exec),
        .rs_data   (rs_data),
        .i_data    (i_data),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit               armed = 1'b0;
    logic [DataW-1:0] exp_out[$];
    logic [DataW-1:0] exp_in[$];
    int               m_occ;
    bit               m_in_full;
    logic [DataW-1:0] m_in_word;
    int               m_cnt;

    bit               p_in, p_out, p_stall;
    int               p_occ0;
    bit               n_in, n_out, n_stall;
    logic [DataW-1:0] n_exp;

    function automatic bit decode(input logic [15:0] i, input logic [3:0] op);
        return (i[15:14] == 2'b11) && (i[7:4] == op);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: advances on each rising edge using the inputs held during the cycle.
    always @(posedge clk) begin
        if (rst) begin
            armed     = 1'b1;
            exp_out.delete();
            exp_in.delete();
            m_occ     = 0;
            m_in_full = 1'b0;
            m_in_word = '0;
            m_cnt     = 0;
        end else if (armed) begin
            p_in    = exec && decode(instr, 4'hC);
            p_out   = exec && decode(instr, 4'hD);
            p_stall = (p_in && !m_in_full) || (p_out && m_occ == Depth);
            if (p_stall && m_cnt != 16'hFFFF) m_cnt++;
            p_occ0 = m_occ;
            if (p_out && p_occ0 < Depth) begin
                exp_out.push_back(rs_data);
                m_occ++;
            end
            if (p_occ0 > 0 && out_ready) m_occ--;
            if (p_in && m_in_full) begin
                m_in_full = 1'b0;
            end else if (in_valid && !m_in_full) begin
                m_in_full = 1'b1;
                m_in_word = in_data;
                exp_in.push_back(in_data);
            end
        end
    end

    // Monitor: samples mid-cycle and scoreboards every completed handshake.
    always @(negedge clk) begin
        if (armed) begin
            n_in    = exec && decode(instr, 4'hC);
            n_out   = exec && decode(instr, 4'hD);
            n_stall = !rst && ((n_in && !m_in_full) || (n_out && m_occ == Depth));
            check("stall", 32'(stall), 32'(n_stall));
            check("in_ready", 32'(in_ready), 32'(!m_in_full));
            check("out_valid", 32'(out_valid), 32'(m_occ != 0));
            check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            check("i_data", 32'(i_data), 32'(m_in_word));
            if (!rst && out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    check("out_pop_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    n_exp = exp_out.pop_front();
                    check("out_data", 32'(out_data), 32'(n_exp));
                end
            end else if (!out_valid) begin
                check("out_data_empty", 32'(out_data), 32'd0);
            end
            if (!rst && n_in && !stall) begin
                if (exp_in.size() == 0) begin
                    check("in_consume_unexpected", 32'(stall), 32'd1);
                end else begin
                    n_exp = exp_in.pop_front();
                    check("in_consume", 32'(i_data), 32'(n_exp));
                end
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic [15:0] ins,
                         input logic [15:0] rs, input logic iv, input logic [15:0] id,
                         input logic ordy);
        rst       = r;
        exec      = e;
        instr     = ins;
        rs_data   = rs;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] InOp  = 16'hC0C0;
    localparam logic [15:0] OutOp = 16'hC0D0;

    logic [15:0] r_instr;
    int          k;

    initial begin
        rst = 1'b1; exec = 1'b0; instr = '0; rs_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        drive(1, 0, 16'h0000, 16'h0, 0, 16'h0, 0);
        drive(1, 0, 16'h0000, 16'h0, 0, 16'h0, 0);
        // Idle and non-I/O instruction
        drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 0);
        drive(0, 1, 16'hC000, 16'h5555, 0, 16'h0, 0);
        // Single OUT streamed straight through
        drive(0, 1, OutOp, 16'h1234, 0, 16'h0, 1);
        drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 1);
        drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 1);
        // Backpressure: four accepted, fifth stalls until a pop has freed a slot
        for (int i = 1; i <= 4; i++) drive(0, 1, OutOp, 16'(i), 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, OutOp, 16'd5, 0, 16'h0, 0);
        drive(0, 1, OutOp, 16'd5, 0, 16'h0, 1);
        drive(0, 1, OutOp, 16'd5, 0, 16'h0, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 1);
        // IN before data arrives
        for (int i = 0; i < 3; i++) drive(0, 1, InOp, 16'h0, 0, 16'h0, 0);
        drive(0, 1, InOp, 16'h0, 1, 16'hBEEF, 0);
        drive(0, 1, InOp, 16'h0, 0, 16'h0, 0);
        drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 0);
        // Prefetched IN, then a second IN that stalls and is flushed
        drive(0, 0, 16'h0000, 16'h0, 1, 16'h00A5, 0);
        drive(0, 1, InOp, 16'h0, 0, 16'h0, 0);
        drive(0, 1, InOp, 16'h0, 0, 16'h0, 0);
        drive(0, 1, InOp, 16'h0, 0, 16'h0, 0);
        drive(0, 0, InOp, 16'h0, 0, 16'h0, 0);
        drive(0, 0, 16'h0000, 16'h0, 1, 16'h1111, 0);
        drive(0, 1, InOp, 16'h0, 1, 16'h2222, 0);
        // Reset with words queued and an input buffered
        for (int i = 0; i < 3; i++) drive(0, 1, OutOp, 16'hA000 + 16'(i), 1, 16'h3333, 0);
        drive(1, 1, OutOp, 16'hDEAD, 1, 16'h4444, 1);
        drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 1);
        drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 1);
        // Random traffic
        for (int i = 0; i < 700; i++) begin
            k = int'($urandom_range(0, 9));
            r_instr = 16'($urandom);
            if (k < 4) begin
                r_instr[15:14] = 2'b11; r_instr[7:4] = 4'hC;
            end else if (k < 8) begin
                r_instr[15:14] = 2'b11; r_instr[7:4] = 4'hD;
            end else if (k == 8) begin
                r_instr[15:14] = 2'b10; r_instr[7:4] = 4'hD;
            end
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 7), r_instr,
                  16'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom),
                  ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6; i++) drive(0, 0, 16'h0000, 16'h0, 0, 16'h0, 1);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
